// File: rtl/gfsk_demod_pkg.sv
// Shared BTLE receive constants: disc, accumulator and phase-counter widths
// plus the strobe bundle carried alongside discriminator data.
package gfsk_demod_pkg;

  function automatic int clog2i(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int disc_w(input int iqw);
    return 2 * iqw + 1;
  endfunction

  function automatic int acc_w(input int iqw, input int sps);
    return disc_w(iqw) + clog2i(sps);
  endfunction

  function automatic int phase_w(input int sps);
    return (clog2i(sps) < 1) ? 1 : clog2i(sps);
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
  } strobe_t;

endpackage

// File: rtl/gfsk_demodulation_fm_discriminator.sv
// Three-stage cross-product FM discriminator with packet priming.
// disc = i_prev*q_cur - q_prev*i_cur, positive for CCW rotation.
module fm_discriminator
  import gfsk_demod_pkg::*;
#(
  parameter int IQ_BIT_WIDTH = 8,
  localparam int DW = disc_w(IQ_BIT_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [IQ_BIT_WIDTH-1:0] i_in,
  input  logic signed [IQ_BIT_WIDTH-1:0] q_in,
  input  logic                           iq_valid,
  input  logic                           iq_valid_last,
  output logic signed [DW-1:0]           disc,
  output logic                           disc_valid,
  output logic                           disc_valid_last
);

  localparam int W = IQ_BIT_WIDTH;

  logic signed [W-1:0]   i_cur;
  logic signed [W-1:0]   q_cur;
  logic signed [W-1:0]   i_prev;
  logic signed [W-1:0]   q_prev;
  logic                  primed;
  strobe_t               s1;
  strobe_t               s2;
  logic signed [2*W-1:0] p_a;
  logic signed [2*W-1:0] p_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cur           <= '0;
      q_cur           <= '0;
      i_prev          <= '0;
      q_prev          <= '0;
      primed          <= 1'b0;
      s1              <= '0;
      s2              <= '0;
      p_a             <= '0;
      p_b             <= '0;
      disc            <= '0;
      disc_valid      <= 1'b0;
      disc_valid_last <= 1'b0;
    end else begin
      // A sample ending a packet leaves the next one to re-prime.
      if (iq_valid) begin
        i_cur  <= i_in;
        q_cur  <= q_in;
        i_prev <= i_cur;
        q_prev <= q_cur;
        primed <= !iq_valid_last;
      end
      s1.valid <= iq_valid && primed;
      s1.last  <= iq_valid && iq_valid_last && primed;
      if (s1.valid) begin
        p_a <= i_prev * q_cur;
        p_b <= q_prev * i_cur;
      end
      s2 <= s1;
      if (s2.valid)
        disc <= {p_a[2*W-1], p_a} - {p_b[2*W-1], p_b};
      disc_valid      <= s2.valid;
      disc_valid_last <= s2.last;
    end
  end

endmodule

// File: rtl/gfsk_demodulation.sv
// GFSK demodulator: FM discriminator plus symbol-rate hard decision.
// GFSK_DEMOD_INTEGRATE_EN selects integrate-and-dump over single-sample.
module gfsk_demodulation
  import gfsk_demod_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int IQ_BIT_WIDTH      = 8,
  parameter int DECISION_PHASE    = 4,
  localparam int DW = disc_w(IQ_BIT_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [IQ_BIT_WIDTH-1:0] i_in,
  input  logic signed [IQ_BIT_WIDTH-1:0] q_in,
  input  logic                           iq_valid,
  input  logic                           iq_valid_last,
  output logic signed [DW-1:0]           disc,
  output logic                           disc_valid,
  output logic                           disc_valid_last,
  output logic                           phy_bit,
  output logic                           bit_valid,
  output logic                           bit_valid_last
);

  localparam int PW = phase_w(SAMPLE_PER_SYMBOL);
  localparam logic [PW-1:0] LAST_PH = PW'(SAMPLE_PER_SYMBOL - 1);

  logic [PW-1:0] phase;
  logic          end_sym;

  fm_discriminator #(
    .IQ_BIT_WIDTH (IQ_BIT_WIDTH)
  ) u_disc (
    .clk             (clk),
    .rst             (rst),
    .i_in            (i_in),
    .q_in            (q_in),
    .iq_valid        (iq_valid),
    .iq_valid_last   (iq_valid_last),
    .disc            (disc),
    .disc_valid      (disc_valid),
    .disc_valid_last (disc_valid_last)
  );

  assign end_sym = (phase == LAST_PH) || disc_valid_last;

`ifdef GFSK_DEMOD_INTEGRATE_EN
  localparam int AW = acc_w(IQ_BIT_WIDTH, SAMPLE_PER_SYMBOL);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;

  always_comb begin
    sum = acc + {{(AW-DW){disc[DW-1]}}, disc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc            <= '0;
      phase          <= '0;
      phy_bit        <= 1'b0;
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
    end else begin
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
      if (disc_valid) begin
        phase <= end_sym ? '0 : phase + 1'b1;
        acc   <= end_sym ? '0 : sum;
        if (end_sym) begin
          bit_valid      <= 1'b1;
          bit_valid_last <= disc_valid_last;
          phy_bit        <= !sum[AW-1];
        end
      end
    end
  end
`else
  localparam logic [PW-1:0] DEC_PH = PW'(DECISION_PHASE);

  logic dec_hold;
  logic disc_pos;

  assign disc_pos = !disc[DW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_hold       <= 1'b0;
      phase          <= '0;
      phy_bit        <= 1'b0;
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
    end else begin
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
      if (disc_valid) begin
        phase <= end_sym ? '0 : phase + 1'b1;
        if (phase == DEC_PH)
          dec_hold <= disc_pos;
        // Flush before the decision phase falls back to this sample.
        if (end_sym) begin
          bit_valid      <= 1'b1;
          bit_valid_last <= disc_valid_last;
          phy_bit        <= (phase <= DEC_PH) ? disc_pos : dec_hold;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gfsk_demodulation.sv
// Directed bench for gfsk_demodulation: packet table plus reset,
// back-to-back and decision-mode sequences.
module tb_gfsk_demodulation;

  localparam int SPS = 8;
  localparam int W   = 8;
  localparam int DW  = 2 * W + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [W-1:0]  i_in;
  logic signed [W-1:0]  q_in;
  logic                 iq_valid;
  logic                 iq_valid_last;
  logic signed [DW-1:0] disc;
  logic                 disc_valid;
  logic                 disc_valid_last;
  logic                 phy_bit;
  logic                 bit_valid;
  logic                 bit_valid_last;

  gfsk_demodulation #(
    .SAMPLE_PER_SYMBOL (SPS),
    .IQ_BIT_WIDTH      (W),
    .DECISION_PHASE    (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_in            (i_in),
    .q_in            (q_in),
    .iq_valid        (iq_valid),
    .iq_valid_last   (iq_valid_last),
    .disc            (disc),
    .disc_valid      (disc_valid),
    .disc_valid_last (disc_valid_last),
    .phy_bit         (phy_bit),
    .bit_valid       (bit_valid),
    .bit_valid_last  (bit_valid_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int exp_disc[$];
  int bit_val[$];
  int bit_last[$];
  int bit_cyc[$];
  int ndisc;
  int samp_cyc[64];
  int ii[4] = '{100, 0, -100, 0};
  int qq[4] = '{0, 100, 0, -100};

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (disc_valid) begin
        ndisc++;
        if (exp_disc.size() == 0)
          check("disc_unexpected", int'(disc), 0 - 1);
        else
          check("disc", int'(disc), exp_disc.pop_front());
      end
      if (bit_valid) begin
        bit_val.push_back(int'(phy_bit));
        bit_last.push_back(int'(bit_valid_last));
        bit_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_obs();
    exp_disc.delete();
    bit_val.delete();
    bit_last.delete();
    bit_cyc.delete();
    ndisc = 0;
  endtask

  task automatic build(input int n, input int dir, output int q[$]);
    int a;
    a = 0;
    q.delete();
    for (int k = 0; k < n; k++) begin
      q.push_back(a);
      a = (a + dir) & 3;
    end
  endtask

  task automatic send(input int ang[$], input bit gap, input bit last_en);
    int p;
    for (int k = 0; k < ang.size(); k++) begin
      @(negedge clk);
      i_in          = W'(ii[ang[k]]);
      q_in          = W'(qq[ang[k]]);
      iq_valid      = 1'b1;
      iq_valid_last = last_en && (k == ang.size() - 1);
      samp_cyc[k]   = cyc;
      if (k > 0) begin
        p = ang[k-1];
        exp_disc.push_back(ii[p] * qq[ang[k]] - qq[p] * ii[ang[k]]);
      end
      if (gap) begin
        @(negedge clk);
        iq_valid      = 1'b0;
        iq_valid_last = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    iq_valid      = 1'b0;
    iq_valid_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string name;
    int    n;
    int    dir;
    bit    gap;
    int    nbits;
    int    val;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int ang[$];
    int ang2[$];
    int idx;
    int exp_int;

    tbl[0] = '{"ccw33",     33,  1, 1'b0, 4, 1};
    tbl[1] = '{"cw33",      33, -1, 1'b0, 4, 0};
    tbl[2] = '{"ccw20",     20,  1, 1'b0, 3, 1};
    tbl[3] = '{"ccw33_gap", 33,  1, 1'b1, 4, 1};
    tbl[4] = '{"cw20_gap",  20, -1, 1'b1, 3, 0};

    rst           = 1'b1;
    i_in          = '0;
    q_in          = '0;
    iq_valid      = 1'b0;
    iq_valid_last = 1'b0;
    clear_obs();
    repeat (3) @(negedge clk);
    check("rst_disc", int'(disc), 0);
    check("rst_strobes",
          int'({disc_valid, disc_valid_last, bit_valid, bit_valid_last}), 0);
    check("rst_phy_bit", int'(phy_bit), 0);
    rst = 1'b0;
    idle(2);

    for (int c = 0; c < 5; c++) begin
      clear_obs();
      build(tbl[c].n, tbl[c].dir, ang);
      send(ang, tbl[c].gap, 1'b1);
      idle(10);
      check({tbl[c].name, "_ndisc"}, ndisc, tbl[c].n - 1);
      check({tbl[c].name, "_nbits"}, bit_val.size(), tbl[c].nbits);
      check({tbl[c].name, "_disc_left"}, exp_disc.size(), 0);
      for (int j = 0; j < tbl[c].nbits && j < bit_val.size(); j++) begin
        idx = (SPS * (j + 1) < tbl[c].n - 1) ? SPS * (j + 1) : tbl[c].n - 1;
        check({tbl[c].name, "_bit"}, bit_val[j], tbl[c].val);
        check({tbl[c].name, "_last"}, bit_last[j],
              int'(j == tbl[c].nbits - 1));
        check({tbl[c].name, "_bit_cyc"}, bit_cyc[j], samp_cyc[idx] + 4);
      end
    end

    // Reset mid-symbol, then a fresh 17-sample packet.
    clear_obs();
    build(5, 1, ang);
    send(ang, 1'b0, 1'b0);
    @(negedge clk);
    iq_valid = 1'b0;
    rst      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_quiet",
            int'({disc_valid, disc_valid_last, bit_valid, bit_valid_last}), 0);
      check("rst_mid_disc", int'(disc), 0);
    end
    rst = 1'b0;
    clear_obs();
    idle(2);
    build(17, 1, ang);
    send(ang, 1'b0, 1'b1);
    idle(10);
    check("rst_pkt_ndisc", ndisc, 16);
    check("rst_pkt_nbits", bit_val.size(), 2);
    if (bit_val.size() == 2) begin
      check("rst_pkt_bit0", bit_val[0], 1);
      check("rst_pkt_bit1", bit_val[1], 1);
      check("rst_pkt_last0", bit_last[0], 0);
      check("rst_pkt_last1", bit_last[1], 1);
    end

    // Back-to-back packets, no idle between them.
    clear_obs();
    build(9, 1, ang);
    build(9, -1, ang2);
    send(ang, 1'b0, 1'b1);
    send(ang2, 1'b0, 1'b1);
    idle(10);
    check("b2b_ndisc", ndisc, 16);
    check("b2b_nbits", bit_val.size(), 2);
    check("b2b_disc_left", exp_disc.size(), 0);
    if (bit_val.size() == 2) begin
      check("b2b_bit0", bit_val[0], 1);
      check("b2b_bit1", bit_val[1], 0);
      check("b2b_last0", bit_last[0], 1);
      check("b2b_last1", bit_last[1], 1);
    end

    // Discs - - - - + + + - : sum negative, phase 4 positive.
    clear_obs();
    ang = '{0, 3, 2, 1, 0, 1, 2, 3, 2};
`ifdef GFSK_DEMOD_INTEGRATE_EN
    exp_int = 0;
`else
    exp_int = 1;
`endif
    send(ang, 1'b0, 1'b1);
    idle(10);
    check("mode_ndisc", ndisc, 8);
    check("mode_nbits", bit_val.size(), 1);
    if (bit_val.size() == 1) begin
      check("mode_bit", bit_val[0], exp_int);
      check("mode_last", bit_last[0], 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
